// File: rtl/instruction_fetch_unit_if.sv
// Fetch-side bus bundle: instruction-memory request/response, decode handshake,
// execute redirect and queue occupancy. master = fetch unit, slave = environment.
interface instruction_fetch_unit_if #(
  parameter int unsigned FQ_DEPTH = 2
);
  localparam int unsigned CW = $clog2(FQ_DEPTH) + 1;

  logic [63:0]   imem_addr;
  logic [31:0]   imem_data;
  logic          if_valid;
  logic          if_ready;
  logic [31:0]   if_instr;
  logic [63:0]   if_pc;
  logic          redirect_valid;
  logic [63:0]   redirect_pc;
  logic [CW-1:0] fq_count;

  modport master (
    output imem_addr,
    input  imem_data,
    output if_valid,
    input  if_ready,
    output if_instr,
    output if_pc,
    input  redirect_valid,
    input  redirect_pc,
    output fq_count
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    input  if_valid,
    output if_ready,
    input  if_instr,
    input  if_pc,
    output redirect_valid,
    output redirect_pc,
    input  fq_count
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: registered PC, circular fetch queue, decode handshake, redirect flush.
// Optional IFU_PERF_CNT_EN adds saturating fetched/stalled performance counters.
module instruction_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned FQ_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  instruction_fetch_unit_if.master bus
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [63:0]              perf_fetched,
  output logic [63:0]              perf_stalled
`endif
);

  localparam int unsigned PW = $clog2(FQ_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  if (FQ_DEPTH < 2 || (FQ_DEPTH & (FQ_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FQ_DEPTH must be a power of two and at least 2");
  end
  if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
    $error("RESET_PC must be 4-byte aligned");
  end

  logic [63:0] pc_q, pc_d;
  ptr_t        head_q, head_d;
  ptr_t        tail_q, tail_d;
  cnt_t        count_q, count_d;

  logic [63:0] fq_pc_q    [FQ_DEPTH];
  logic [31:0] fq_instr_q [FQ_DEPTH];

  logic empty, full, pop, push;
  logic unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == cnt_t'(FQ_DEPTH));
    pop     = ~empty & bus.if_ready;
    push    = ~bus.redirect_valid & (~full | pop);

    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    // A same-cycle pop still completes; the flush then discards the rest.
    if (bus.redirect_valid) begin
      pc_d    = {bus.redirect_pc[63:2], 2'b00};
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (pop) begin
        head_d = head_q + ptr_t'(1);
      end
      if (push) begin
        tail_d = tail_q + ptr_t'(1);
        pc_d   = pc_q + 64'd4;
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + cnt_t'(1);
        2'b01:   count_d = count_q - cnt_t'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset; occupancy alone qualifies it.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      fq_pc_q[tail_q]    <= pc_q;
      fq_instr_q[tail_q] <= bus.imem_data;
    end
  end

  assign bus.imem_addr = pc_q;
  assign bus.if_valid  = ~empty;
  assign bus.if_pc     = fq_pc_q[head_q];
  assign bus.if_instr  = fq_instr_q[head_q];
  assign bus.fq_count  = count_q;

`ifdef IFU_PERF_CNT_EN
  logic [63:0] fetched_q, stalled_q;
  logic        stall;

  assign stall = ~bus.redirect_valid & full & ~pop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetched_q <= '0;
      stalled_q <= '0;
    end else begin
      if (push && fetched_q != '1) begin
        fetched_q <= fetched_q + 64'd1;
      end
      if (stall && stalled_q != '1) begin
        stalled_q <= stalled_q + 64'd1;
      end
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_stalled = stalled_q;
`endif

endmodule
